// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default widths,
// FSM state encoding and owner constants.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory bus.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arbiter_pkg::DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_valid;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_valid, m_we, m_be, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_valid, m_we, m_be, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of consecutive data wins taken while a fetch was waiting.
// sat tells the arbiter that the fetch port must win the next arbitration.
module arb_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic srst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int            CW    = ctr_width(MAX);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Clear dominates increment; the count sticks at MAX until cleared.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != MAX_C)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign sat = (cnt_reg == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with one
// transaction outstanding at a time and starvation protection for fetches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          owner,
  output logic          err_spurious
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic              owner_reg;
  logic              m_we_reg;
  logic [BE_W-1:0]   m_be_reg;
  logic [ADDR_W-1:0] m_addr_reg;
  logic [DATA_W-1:0] m_wdata_reg;
  logic              err_reg;

  logic              any_req;
  logic              fetch_wins;
  logic              load_en;
  logic              starve_inc;
  logic              starve_clr;
  logic              starve_sat;
  logic [BE_W-1:0]   be_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              issue_ack;
  logic              resp_ack;
  logic              i_rvalid_int;
  logic              d_rvalid_int;

  assign any_req    = bus.i_req | bus.d_req;
  assign fetch_wins = bus.i_req & (~bus.d_req | starve_sat);

  // A fetch drives all byte lanes enabled and zero write data.
  genvar gi;
  for (gi = 0; gi < BE_W; gi++) begin : g_lane
    assign be_sel[gi]            = fetch_wins ? 1'b1 : bus.d_be[gi];
    assign wdata_sel[gi*8 +: 8]  = fetch_wins ? 8'h00 : bus.d_wdata[gi*8 +: 8];
  end

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .srst (rst),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .sat  (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Requests are only looked at in IDLE; WAIT always returns through IDLE.
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
          load_en    = 1'b1;
          if (fetch_wins || !bus.i_req) begin
            starve_clr = 1'b1;
          end else begin
            starve_inc = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg   <= OWNER_FETCH;
      m_we_reg    <= 1'b0;
      m_be_reg    <= '0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
    end else if (load_en) begin
      owner_reg   <= fetch_wins ? OWNER_FETCH : OWNER_DATA;
      m_we_reg    <= ~fetch_wins & bus.d_we;
      m_be_reg    <= be_sel;
      m_addr_reg  <= fetch_wins ? bus.i_addr : bus.d_addr;
      m_wdata_reg <= wdata_sel;
    end
  end

  // A response while no transaction is waiting is dropped and remembered.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (bus.m_rvalid && (state_reg != WAIT)) begin
      err_reg <= 1'b1;
    end
  end

  assign issue_ack    = ~rst & (state_reg == ISSUE) & bus.m_ready;
  assign resp_ack     = ~rst & (state_reg == WAIT) & bus.m_rvalid;
  assign i_rvalid_int = resp_ack & (owner_reg == OWNER_FETCH);
  assign d_rvalid_int = resp_ack & (owner_reg == OWNER_DATA);

  assign bus.i_gnt    = issue_ack & (owner_reg == OWNER_FETCH);
  assign bus.d_gnt    = issue_ack & (owner_reg == OWNER_DATA);
  assign bus.i_rvalid = i_rvalid_int;
  assign bus.d_rvalid = d_rvalid_int;
  assign bus.i_rdata  = i_rvalid_int ? bus.m_rdata : '0;
  // Stores complete with zero read data.
  assign bus.d_rdata  = (d_rvalid_int && !m_we_reg) ? bus.m_rdata : '0;

  assign bus.m_valid  = (state_reg == ISSUE);
  assign bus.m_we     = m_we_reg;
  assign bus.m_be     = m_be_reg;
  assign bus.m_addr   = m_addr_reg;
  assign bus.m_wdata  = m_wdata_reg;

  assign busy         = (state_reg != IDLE);
  assign owner        = owner_reg;
  assign err_spurious = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a random
// run, all checked against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic owner;
  logic err_spurious;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .owner        (owner),
    .err_spurious (err_spurious)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the one transaction in flight and its progress.
  typedef struct packed {
    logic        own;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t cur;
  bit   mf_busy = 0;
  bit   mf_acc  = 0;
  bit   m_err   = 0;
  int   m_starve = 0;

  // Environment: requesters and memory.
  bit          rnd_mode = 0;
  bit          i_pend = 0, d_pend = 0, hold_i = 0, hold_d = 0;
  logic [31:0] i_addr_v = '0, d_addr_v = '0, d_wdata_v = '0;
  logic        d_we_v = 1'b0;
  logic [3:0]  d_be_v = '0;
  bit          mem_wait = 0;
  int          mem_dly = 0;
  logic [15:0] ord = '0;
  int          n_gr = 0, n_irv = 0, n_drv = 0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_wdata = '0, cap_drdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the model for the current inputs, then advance the model.
  task automatic sample_cycle();
    logic exp_mv, exp_ig, exp_dg, exp_ir, exp_dr, fw;
    #3;
    exp_mv = mf_busy && !mf_acc;
    chk("m_valid", bus.m_valid, exp_mv);
    chk("busy", busy, mf_busy);
    chk("err_spurious", err_spurious, m_err);
    if (mf_busy) chk("owner", owner, cur.own);
    if (exp_mv) begin
      chk("m_we_be", {bus.m_we, bus.m_be}, {cur.we, cur.be});
      chk("m_addr", bus.m_addr, cur.addr);
      chk("m_wdata", bus.m_wdata, cur.wdata);
    end
    exp_ig = !rst && exp_mv && bus.m_ready && !cur.own;
    exp_dg = !rst && exp_mv && bus.m_ready && cur.own;
    exp_ir = !rst && mf_busy && mf_acc && bus.m_rvalid && !cur.own;
    exp_dr = !rst && mf_busy && mf_acc && bus.m_rvalid && cur.own;
    chk("i_gnt", bus.i_gnt, exp_ig);
    chk("d_gnt", bus.d_gnt, exp_dg);
    chk("i_rvalid", bus.i_rvalid, exp_ir);
    chk("d_rvalid", bus.d_rvalid, exp_dr);
    chk("i_rdata", bus.i_rdata, exp_ir ? bus.m_rdata : 32'h0);
    chk("d_rdata", bus.d_rdata, (exp_dr && !cur.we) ? bus.m_rdata : 32'h0);

    if (rst) begin
      mf_busy = 0; mf_acc = 0; m_starve = 0; m_err = 0;
    end else begin
      if (bus.m_rvalid && !(mf_busy && mf_acc)) m_err = 1;
      if (!mf_busy) begin
        if (bus.i_req || bus.d_req) begin
          fw = bus.i_req && (!bus.d_req || m_starve == SMAX);
          if (fw) begin
            cur = '{own: 1'b0, we: 1'b0, be: 4'hF, addr: bus.i_addr, wdata: 32'h0};
            m_starve = 0;
          end else begin
            cur = '{own: 1'b1, we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
            m_starve = !bus.i_req ? 0 : ((m_starve < SMAX) ? m_starve + 1 : SMAX);
          end
          mf_busy = 1;
          mf_acc  = 0;
        end
      end else if (!mf_acc) begin
        if (bus.m_ready) mf_acc = 1;
      end else if (bus.m_rvalid) begin
        mf_busy = 0;
      end
    end
  endtask

  task automatic tick();
    sample_cycle();
    next_edge();
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    i_pend = 0; d_pend = 0; hold_i = 0; hold_d = 0; mem_wait = 0;
    repeat (2) tick();
    rst = 0;
  endtask

  // One cycle of requester + memory behaviour; random when rnd_mode is set.
  task automatic env_cycle();
    bit fire, spur;
    if (rnd_mode) begin
      if (!i_pend && $urandom_range(0, 3) == 0) begin
        i_pend = 1; i_addr_v = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we_v = 1'($urandom); d_be_v = 4'($urandom);
        d_addr_v = $urandom; d_wdata_v = $urandom;
      end
      bus.m_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.m_ready = 1;
    end
    bus.i_req = i_pend; bus.i_addr = i_addr_v;
    bus.d_req = d_pend; bus.d_we = d_we_v; bus.d_be = d_be_v;
    bus.d_addr = d_addr_v; bus.d_wdata = d_wdata_v;
    fire = mem_wait && (mem_dly == 0);
    spur = rnd_mode && !mem_wait && ($urandom_range(0, 199) == 0);
    bus.m_rvalid = fire || spur;
    bus.m_rdata  = $urandom;
    sample_cycle();
    if (bus.i_gnt || bus.d_gnt) begin
      ord = {ord[14:0], bus.i_gnt};
      n_gr++;
    end
    if (bus.i_gnt && !hold_i) i_pend = 0;
    if (bus.d_gnt) begin
      cap_we = bus.m_we; cap_wdata = bus.m_wdata;
      if (!hold_d) d_pend = 0;
    end
    if (bus.i_rvalid) n_irv++;
    if (bus.d_rvalid) begin
      n_drv++; cap_drdata = bus.d_rdata;
    end
    if (fire) mem_wait = 0;
    else if (mem_wait) mem_dly--;
    if (bus.m_valid && bus.m_ready) begin
      mem_wait = 1;
      mem_dly  = rnd_mode ? $urandom_range(0, 2) : 0;
    end
    next_edge();
  endtask

  task automatic lone_fetch(input logic [31:0] addr, input logic [31:0] data);
    idle_inputs();
    bus.i_req = 1; bus.i_addr = addr; bus.m_ready = 1;
    sample_cycle(); chk("lone_idle_gnt", bus.i_gnt, 0); next_edge();
    sample_cycle(); chk("lone_gnt", bus.i_gnt, 1); chk("lone_m_addr", bus.m_addr, addr); next_edge();
    bus.i_req = 0; bus.m_rvalid = 1; bus.m_rdata = data;
    sample_cycle();
    chk("lone_rvalid", bus.i_rvalid, 1);
    chk("lone_rdata", bus.i_rdata, data);
    chk("lone_d_quiet", {bus.d_gnt, bus.d_rvalid, bus.d_rdata}, 0);
    next_edge();
    idle_inputs();
    sample_cycle(); chk("lone_busy_after", busy, 0); next_edge();
  endtask

  initial begin
    int gcount;
    rst = 1;
    idle_inputs();
    next_edge();
    do_reset();

    // Reset state
    sample_cycle();
    chk("rst_m_ctl", {bus.m_valid, bus.m_we, bus.m_be}, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_status", {busy, owner, err_spurious}, 0);
    next_edge();

    // Lone fetch
    lone_fetch(32'h0000_0010, 32'h0050_0093);

    // Contention: store wins, then the fetch
    do_reset();
    ord = '0; n_gr = 0; n_irv = 0; n_drv = 0; cap_drdata = 32'hFFFF_FFFF;
    i_pend = 1; i_addr_v = 32'h20;
    d_pend = 1; d_we_v = 1; d_be_v = 4'hF; d_addr_v = 32'h100; d_wdata_v = 32'hDEAD_BEEF;
    repeat (12) env_cycle();
    chk("cont_ngrants", n_gr, 2);
    chk("cont_order", ord, 16'h0001);
    chk("cont_m_we", cap_we, 1);
    chk("cont_m_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("cont_d_rdata", cap_drdata, 0);
    chk("cont_completions", {n_drv[7:0], n_irv[7:0]}, 16'h0101);

    // Starvation: both ports held high
    do_reset();
    ord = '0; n_gr = 0;
    i_pend = 1; hold_i = 1; i_addr_v = 32'h40;
    d_pend = 1; hold_d = 1; d_we_v = 0; d_be_v = 4'h3; d_addr_v = 32'h200; d_wdata_v = 32'h1234;
    for (int k = 0; k < 100 && n_gr < 10; k++) env_cycle();
    chk("starve_ngrants", n_gr, 10);
    chk("starve_order", ord, 16'h0021);
    i_pend = 0; d_pend = 0; hold_i = 0; hold_d = 0;
    repeat (4) env_cycle();

    // Backpressure: three cycles of m_ready low in ISSUE
    do_reset();
    gcount = 0;
    bus.i_req = 1; bus.i_addr = 32'h44;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.m_ready = (k == 3);
      sample_cycle();
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_addr", bus.m_addr, 32'h44);
      gcount += int'(bus.i_gnt);
      next_edge();
      bus.i_req = 0;
    end
    bus.m_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hCAFE_0001;
    sample_cycle(); gcount += int'(bus.i_gnt); chk("bp_rvalid", bus.i_rvalid, 1); next_edge();
    idle_inputs();
    sample_cycle(); gcount += int'(bus.i_gnt); next_edge();
    chk("bp_gnt_count", gcount, 1);

    // Reset while waiting for the response
    do_reset();
    bus.i_req = 1; bus.i_addr = 32'h80; bus.m_ready = 1;
    tick();
    tick();
    bus.i_req = 0; bus.m_ready = 0;
    rst = 1;
    sample_cycle(); chk("rw_rst_quiet", {bus.i_gnt, bus.i_rvalid}, 0); next_edge();
    rst = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h5555_AAAA;
    sample_cycle(); chk("rw_no_rvalid", bus.i_rvalid, 0); chk("rw_idle", busy, 0); next_edge();
    bus.m_rvalid = 0;
    sample_cycle(); chk("rw_err", err_spurious, 1); next_edge();

    // Spurious response in IDLE, then a normal fetch
    do_reset();
    bus.m_rvalid = 1; bus.m_rdata = 32'h0BAD_0BAD;
    sample_cycle(); chk("sp_no_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0); next_edge();
    bus.m_rvalid = 0;
    repeat (3) begin
      sample_cycle(); chk("sp_err_held", err_spurious, 1); next_edge();
    end
    lone_fetch(32'h0000_0100, 32'h1357_9BDF);
    sample_cycle(); chk("sp_err_after", err_spurious, 1); next_edge();

    // Random traffic
    do_reset();
    rnd_mode = 1;
    repeat (4000) env_cycle();
    rnd_mode = 0;
    repeat (20) env_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, number of consecutive data grants after which a waiting fetch request wins.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_req / i_addr  input  1 / ADDR_W  fetch request; held with a stable address until i_gnt.
REQ-007 i_gnt / i_rvalid / i_rdata  output  1 / 1 / DATA_W  fetch accepted pulse; read-data valid pulse; read data.
REQ-008 d_req / d_we / d_be / d_addr / d_wdata  input  1 / 1 / DATA_W/8 / ADDR_W / DATA_W  load/store request; all fields held stable until d_gnt.
REQ-009 d_gnt / d_rvalid / d_rdata  output  1 / 1 / DATA_W  data accepted pulse; completion pulse (loads and stores); read data.
REQ-010 m_valid / m_we / m_be / m_addr / m_wdata  output  1 / 1 / DATA_W/8 / ADDR_W / DATA_W  single-port memory request, registered.
REQ-011 m_ready / m_rvalid / m_rdata  input  1 / 1 / DATA_W  memory accept; response valid (one pulse per accepted request); read data.
REQ-012 busy / owner / err_spurious  output  1 / 1 / 1  state != IDLE; current owner (0 = fetch, 1 = data); sticky spurious-response flag.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE and WAIT; only one memory transaction is ever outstanding.
REQ-014 In IDLE with any request, the arbiter SHALL latch the winner into owner, load m_we/m_be/m_addr/m_wdata from the winner, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-015 m_valid SHALL equal (state == ISSUE); for a fetch, m_we = 0, m_be = all ones and m_wdata = 0.
REQ-016 In ISSUE, when m_ready = 1, the arbiter SHALL pulse the owner's gnt in that same cycle and go to WAIT; while m_ready = 0 it SHALL hold ISSUE with all m_* outputs stable.
REQ-017 In WAIT, when m_rvalid = 1, the arbiter SHALL pulse the owner's rvalid in that cycle, pass m_rdata combinationally to the owner's rdata (0 for stores) and go to IDLE.
REQ-018 The owner's rdata SHALL be 0 whenever the owner's rvalid is 0.
REQ-019 Minimum request-to-response time: a request seen in IDLE at cycle N gives gnt at N+1 (if m_ready = 1) and rvalid at N+2 at the earliest (if m_rvalid follows at once).
REQ-020 Throughput SHALL be one IDLE bubble between transactions; WAIT never goes directly to ISSUE.
REQ-021 Priority SHALL be data over fetch when both request in IDLE, except that fetch wins when starve_cnt == STARVE_MAX.
REQ-022 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data win with i_req = 1; it SHALL clear on each fetch win and on any IDLE arbitration where i_req = 0.
REQ-023 m_rvalid outside WAIT SHALL be ignored (no rvalid to any requester) and SHALL set err_spurious, which is held until rst.
REQ-024 Requests are sampled only in IDLE; a deasserted req in ISSUE does not abort the transaction.

Reset
REQ-025 On rst: state = IDLE, owner = 0, starve_cnt = 0, err_spurious = 0, m_valid = 0, m_we = 0, m_be = 0, m_addr = 0, m_wdata = 0, and all gnt/rvalid = 0.
REQ-026 rst during ISSUE or WAIT SHALL abandon the transaction with no gnt and no rvalid; a late m_rvalid after reset SHALL set err_spurious.

Structure
REQ-027 The state encoding (IDLE/ISSUE/WAIT), the OWNER_FETCH/OWNER_DATA constants and the default widths SHALL live in the shared CPU package.
REQ-028 The starvation counter SHALL be one sub-module, arb_starve_ctr (inc, clr, sat output), instantiated once.

Verification
REQ-029 Lone fetch: i_req = 1 with i_addr = 0x00000010, m_ready = 1, m_rdata = 0x00500093 one cycle later -> i_gnt at N+1, i_rvalid at N+2 with i_rdata = 0x00500093, d_* outputs all 0.
REQ-030 Contention: i_req and d_req both high, d_we = 1, d_be = 0xF, d_addr = 0x100, d_wdata = 0xDEADBEEF -> data granted first with m_we = 1 and m_wdata = 0xDEADBEEF, d_rdata = 0 on d_rvalid, then the fetch is served.
REQ-031 Starvation: both requests held high through 5 arbitrations with STARVE_MAX = 4 -> grant order D, D, D, D, I, then starve_cnt = 0.
REQ-032 Backpressure: m_ready held low for 3 cycles in ISSUE -> m_valid high and m_addr stable for 4 cycles, exactly one gnt pulse.
REQ-033 Reset in WAIT: rst for 1 cycle, then m_rvalid = 1 -> no rvalid pulse, state IDLE, err_spurious = 1.
REQ-034 Spurious response in IDLE with no reset: m_rvalid = 1 -> err_spurious = 1 and held; a following fetch still completes normally.
